// File: rtl/fetch_pkg.sv
// Shared types and sizes for the fetch-to-decode instruction queue.
// A fetch block holds SLOTS_PER_BLOCK fixed-width instructions.
package fetch_pkg;

  localparam int XLEN            = 64;
  localparam int FETCH_BYTES     = 32;
  localparam int INSN_W          = 32;
  localparam int SLOTS_PER_BLOCK = FETCH_BYTES * 8 / INSN_W;
  localparam int SLOT_W          = 3;
  localparam int BLOCK_W         = 8 * FETCH_BYTES;
  localparam int OFF_W           = $clog2(FETCH_BYTES);

  typedef struct packed {
    logic [XLEN-1:0]    base;
    logic [SLOT_W-1:0]  start_slot;
    logic [BLOCK_W-1:0] data;
  } fetch_entry_t;

  // PC of a given slot within a block-aligned base address.
  function automatic logic [XLEN-1:0] slot_pc(input logic [XLEN-1:0]   base,
                                               input logic [SLOT_W-1:0] slot);
    return base | XLEN'({slot, 2'b00});
  endfunction

endpackage

// File: rtl/fetch_block_fifo.sv
// Synchronous FIFO of fetch blocks; exposes the head entry and the start
// slot of the entry behind it so the consumer can chain across blocks.
module fetch_block_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  fetch_entry_t      push_entry,
  input  logic              pop,
  output fetch_entry_t      head,
  output logic [SLOT_W-1:0] next_start_slot,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  // Explicit wrap so non-power-of-two depths would still index correctly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked solely by count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  assign head            = mem[rd_ptr];
  assign next_start_slot = mem[ptr_inc(rd_ptr)].start_slot;

endmodule

// File: rtl/fetch_insn_queue.sv
// Buffers fetch blocks and issues one instruction per cycle to decode,
// starting each block at the slot selected by its (possibly unaligned) PC.
module fetch_insn_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    in_pc,
  input  logic [BLOCK_W-1:0] in_block,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSN_W-1:0]  out_insn,
  output logic [XLEN-1:0]    out_pc,
  output logic [CNT_W-1:0]   occupancy
);

  fetch_entry_t      push_entry;
  fetch_entry_t      head;
  logic [SLOT_W-1:0] next_start_slot;
  logic [SLOT_W-1:0] slot;
  logic              push;
  logic              insn_pop;
  logic              blk_pop;
  logic              unused_pc_bits;

  assign unused_pc_bits = ^in_pc[1:0];

  assign in_ready  = (occupancy < CNT_W'(DEPTH)) && !flush && !reset;
  assign out_valid = (occupancy != '0) && !flush && !reset;
  assign push      = in_valid && in_ready;
  assign insn_pop  = out_valid && out_ready;
  assign blk_pop   = insn_pop && (slot == SLOT_W'(SLOTS_PER_BLOCK - 1));

  assign push_entry.base       = {in_pc[XLEN-1:OFF_W], {OFF_W{1'b0}}};
  assign push_entry.start_slot = in_pc[OFF_W-1:2];
  assign push_entry.data       = in_block;

  fetch_block_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk             (clk),
    .reset           (reset),
    .flush           (flush),
    .push            (push),
    .push_entry      (push_entry),
    .pop             (blk_pop),
    .head            (head),
    .next_start_slot (next_start_slot),
    .count           (occupancy)
  );

  // The slot follows the head block; on retire it jumps to whichever block
  // becomes the new head, which may be the one being pushed this cycle.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      slot <= '0;
    end else if (blk_pop) begin
      if (occupancy > CNT_W'(1)) slot <= next_start_slot;
      else if (push)             slot <= push_entry.start_slot;
      else                       slot <= '0;
    end else if (insn_pop) begin
      slot <= slot + 1'b1;
    end else if (push && (occupancy == '0)) begin
      slot <= push_entry.start_slot;
    end
  end

  assign out_insn = head.data[slot * INSN_W +: INSN_W];
  assign out_pc   = slot_pc(head.base, slot);

endmodule

// File: tb/tb_fetch_insn_queue.sv
// Directed and randomized bench for fetch_insn_queue against a block-queue model.
module tb_fetch_insn_queue;
  import fetch_pkg::*;

  localparam int DEPTH = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic [XLEN-1:0]    in_pc;
  logic [BLOCK_W-1:0] in_block;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [INSN_W-1:0]  out_insn;
  logic [XLEN-1:0]    out_pc;
  logic [1:0]         occupancy;

  fetch_insn_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_block  (in_block),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_insn  (out_insn),
    .out_pc    (out_pc),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  // Model: each held block with the index of its next instruction to issue.
  typedef struct {
    logic [63:0]  base;
    int           next;
    logic [255:0] data;
  } blk_t;

  blk_t mq[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  bit   accepted;
  int   issued;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    bit   exp_rdy, exp_vld, pop;
    blk_t b;
    @(negedge clk);
    exp_rdy = (mq.size() < DEPTH) && !flush && !reset;
    exp_vld = (mq.size() != 0) && !flush && !reset;
    check("in_ready", 64'(in_ready), 64'(exp_rdy));
    check("out_valid", 64'(out_valid), 64'(exp_vld));
    check("occupancy", 64'(occupancy), 64'(mq.size()));
    if (exp_vld) begin
      b = mq[0];
      check("out_pc", out_pc, b.base + 64'(b.next * 4));
      check("out_insn", 64'(out_insn), 64'(b.data[b.next*32 +: 32]));
    end
    @(posedge clk);
    accepted = exp_rdy && in_valid;
    pop      = exp_vld && out_ready;
    if (reset || flush) begin
      mq.delete();
    end else begin
      if (pop) begin
        issued++;
        b = mq[0];
        b.next++;
        if (b.next == 8) void'(mq.pop_front());
        else mq[0] = b;
      end
      if (accepted) begin
        b.base = in_pc & ~64'h1F;
        b.next = int'(in_pc[4:2]);
        b.data = in_block;
        mq.push_back(b);
      end
    end
    #1;
  endtask

  task automatic present_rand(input logic [63:0] pc);
    in_pc = pc;
    for (int i = 0; i < 8; i++) in_block[i*32 +: 32] = $urandom;
  endtask

  task automatic present_seq(input logic [63:0] pc, input logic [31:0] w0);
    in_pc = pc;
    for (int i = 0; i < 8; i++) in_block[i*32 +: 32] = w0 + 32'(i);
  endtask

  initial begin
    int n;
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_block = '0; issued = 0;
    repeat (3) cycle();
    reset = 1'b0;
    cycle();

    // Aligned block: eight sequential instructions, then empty.
    out_ready = 1'b1;
    present_seq(64'h1000, 32'h13);
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    issued = 0;
    repeat (10) cycle();
    check("t1_issued", 64'(issued), 64'd8);

    // Entry at slot 3: five instructions.
    present_seq(64'h100C, 32'h40);
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    issued = 0;
    repeat (7) cycle();
    check("t2_issued", 64'(issued), 64'd5);

    // Back-pressure: two blocks fill the queue, third waits.
    out_ready = 1'b0;
    n = 0;
    present_rand(64'h4000);
    in_valid = 1'b1;
    issued = 0;
    for (int c = 0; c < 200 && n < 3; c++) begin
      if (c == 6) out_ready = 1'b1;
      cycle();
      if (accepted) begin
        n++;
        present_rand(64'h4000 + 64'(n * 32));
        if (n == 3) in_valid = 1'b0;
      end
    end
    check("t3_accepts", 64'(n), 64'd3);
    repeat (30) cycle();
    check("t3_issued", 64'(issued), 64'd24);

    // Streaming: blocks offered continuously, decode always ready.
    n = 0;
    present_rand(64'h8000);
    in_valid = 1'b1;
    for (int c = 0; c < 60; c++) begin
      cycle();
      if (accepted) begin
        n++;
        present_rand(64'h8000 + 64'(n * 32));
      end
    end
    in_valid = 1'b0;
    repeat (20) cycle();

    // Flush at slot 4 with a block presented.
    present_rand(64'h3000);
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    for (int c = 0; c < 20 && (mq.size() == 0 || mq[0].next != 4); c++) cycle();
    check("t5_at_slot4", 64'(mq.size() != 0 && mq[0].next == 4), 64'd1);
    flush = 1'b1;
    present_rand(64'h5000);
    in_valid = 1'b1;
    cycle();
    flush = 1'b0;
    in_valid = 1'b0;
    cycle();
    present_rand(64'h2000);
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    @(negedge clk);
    check("t5_first_pc", out_pc, 64'h2000);
    #1;
    @(posedge clk);
    #1;
    mq.delete();
    mq.push_back('{64'h2000, 1, in_block});
    repeat (3) cycle();

    // Reset mid-block for two cycles with a block presented.
    present_rand(64'h6008);
    in_valid = 1'b1;
    cycle();
    reset = 1'b1;
    repeat (2) cycle();
    reset = 1'b0;
    in_valid = 1'b0;
    issued = 0;
    repeat (3) cycle();
    check("t6_no_stale", 64'(issued), 64'd0);

    // Random traffic with unaligned PCs and occasional flushes.
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(99) < 60);
      out_ready = ($urandom_range(99) < 70);
      flush     = ($urandom_range(99) < 3);
      present_rand({$urandom, $urandom});
      cycle();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (20) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
